// File: rtl/ff_pipe.sv
// ff_pipe: elastic DEPTH-stage pipeline register with valid/ready handshake,
// per-stage valid bits and bubble collapse (empty stages fill under a stall).
//
// Parameters:
//   WIDTH  data width in bits (>=1)
//   DEPTH  number of register stages (>=1); stage DEPTH-1 drives the outputs
//   RESET  value loaded into every stage data register on reset
//   CW     width of count; 2**CW must exceed DEPTH
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      drop all beats (only with FF_PIPE_FLUSH_EN defined)
//   in_valid   upstream beat present
//   in_data    upstream payload
//   in_ready   stage 0 accepts a beat this cycle
//   out_valid  output stage holds a valid beat
//   out_data   output stage data register
//   out_ready  downstream accepts the beat
//   count      number of valid stages, 0..DEPTH
//
// Configuration macro:
//   FF_PIPE_FLUSH_EN  adds the flush port and its logic.
//
// in_ready is combinational from out_ready through the advance chain.
// Instantiators must account for that path when closing a loop with it.

module ff_pipe #(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET = '0,
  parameter int unsigned      CW    = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FF_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_v;
  logic [WIDTH-1:0] w_src_d [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;

  // adv[i] = adv[i+1] | ~v[i] unrolls to: out_ready, or any stage at or
  // beyond i is empty. Computing it that way avoids a self-referencing
  // vector in the combinational logic.
  always_comb begin
    w_adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic hole;
      hole = 1'b0;
      for (int j = i; j < DEPTH; j++) begin
        hole = hole | ~r_v[j];
      end
      w_adv[i] = out_ready | hole;
    end
  end

  // Source of each stage: the input port for stage 0, else the stage behind.
  always_comb begin
    w_src_v[0] = in_valid;
    w_src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_v[i] = r_v[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

`ifdef FF_PIPE_FLUSH_EN
  assign in_ready = w_adv[0] & ~flush;
`else
  assign in_ready = w_adv[0];
`endif

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_v[DEPTH-1] & out_ready;

  // Stage registers. Data only loads on a valid source beat, so bubbles
  // moving through the pipe leave the data registers untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET;
      end
    end
`ifdef FF_PIPE_FLUSH_EN
    else if (flush) begin
      r_v <= '0;
    end
`endif
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= w_src_v[i];
          if (w_src_v[i]) begin
            r_d[i] <= w_src_d[i];
          end
        end
      end
    end
  end

  // Occupancy tracks popcount(v): +1 on input only, -1 on output only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end
`ifdef FF_PIPE_FLUSH_EN
    else if (flush) begin
      r_count <= '0;
    end
`endif
    else if (w_in_xfer && !w_out_xfer) begin
      r_count <= r_count + CW'(1);
    end
    else if (!w_in_xfer && w_out_xfer) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_ff_pipe.sv
// Directed testbench for ff_pipe (WIDTH=8, DEPTH=3, RESET=8'hA5).
// Inputs change 1 time unit after each rising edge; outputs sampled 1 unit later.

module tb_ff_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] count;
`ifdef FF_PIPE_FLUSH_EN
  logic       flush;
`endif

  int checks = 0;
  int errors = 0;

  ff_pipe #(
    .WIDTH(8),
    .DEPTH(3),
    .RESET(8'hA5),
    .CW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef FF_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic ov, input logic [7:0] od,
                    input logic [1:0] c, input logic ir);
    chk({tag, ".out_valid"}, 32'(ov ? 1 : 0) ^ 32'(out_valid ? 1 : 0) ^ 32'(ov ? 1 : 0) == 0 ? 32'(out_valid) : 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"}, 32'(out_data), 32'(od));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef FF_PIPE_FLUSH_EN
    flush     = 1'b0;
`endif
    #2;
    st("reset", 1'b0, 8'hA5, 2'd0, 1'b1);
    tick();
    tick();
    rst = 1'b0;

    // Mid-stream asynchronous reset
    in_valid = 1'b1; in_data = 8'h55; tick();
    in_data = 8'h66; tick();
    in_data = 8'h77; tick();
    in_valid = 1'b0;
    #1;
    st("loaded", 1'b1, 8'h55, 2'd3, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    st("async_rst", 1'b0, 8'hA5, 2'd0, 1'b1);
    #2;
    rst = 1'b0;
    tick();

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    st("stream_e2", 1'b0, 8'hA5, 2'd2, 1'b1);
    in_data = 8'h03; tick();
    st("stream_e3", 1'b1, 8'h01, 2'd3, 1'b1);
    in_data = 8'h04; tick();
    st("stream_e4", 1'b1, 8'h02, 2'd3, 1'b1);
    in_valid = 1'b0; tick();
    st("stream_e5", 1'b1, 8'h03, 2'd2, 1'b1);
    tick();
    st("stream_e6", 1'b1, 8'h04, 2'd1, 1'b1);
    tick();
    st("stream_e7", 1'b0, 8'h04, 2'd0, 1'b1);

    // Bubble collapse under a stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h22; tick();
    in_valid = 1'b0; tick();
    tick();
    st("bubble", 1'b1, 8'h11, 2'd2, 1'b1);
    in_valid = 1'b1; in_data = 8'h33; tick();
    in_valid = 1'b0;
    #1;
    st("full", 1'b1, 8'h11, 2'd3, 1'b0);

    // Full pass-through
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h44;
    #1;
    chk("pass.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    st("pass", 1'b1, 8'h22, 2'd3, 1'b1);

    // Drain to empty
    tick();
    st("drain1", 1'b1, 8'h33, 2'd2, 1'b1);
    tick();
    st("drain2", 1'b1, 8'h44, 2'd1, 1'b1);
    tick();
    st("drain3", 1'b0, 8'h44, 2'd0, 1'b1);

`ifdef FF_PIPE_FLUSH_EN
    // Flush with a competing input beat
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h81; tick();
    in_data = 8'h82; tick();
    flush = 1'b1; in_data = 8'h99;
    #1;
    chk("flush.count_pre", 32'(count), 32'd2);
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("flush.nobeat_valid", 32'(out_valid), 32'd0);
    chk("flush.nobeat_count", 32'(count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
